interrupt_request_controller: RTL and testbench
===============================================

// Module: interrupt_request_controller
// PURPOSE
// Request side of the interrupt_handler start/done handshake. Collects RESET (soft_reset), NMI (PPU vblank),
// maskable IRQ and CPU-issued BRK/RTI. Prioritises them and starts interrupt_handler with a one-cycle ih_start
// plus a kind code, then stalls the CPU core until ih_done. Sits between the CPU core, the PPU/APU/mapper
// IRQ sources and interrupt_handler.
// PARAMETERS
// N_IRQ         4    number of level-sensitive IRQ source lines
// DONE_TIMEOUT  64   cycles allowed in WAIT_DONE before abort; 8-bit counter, range 1..255
// PORTS
// clk             in   1      system clock, all logic on rising edge
// rst             in   1      asynchronous, active-low reset
// soft_reset      in   1      active-low soft reset request, level
// ppu_status      in   8      PPU status; bit7 = vblank
// ppu_nmi_en      in   1      PPUCTRL bit7, NMI enable
// irq_lines       in   N_IRQ  level IRQ sources, active-high
// irq_mask        in   N_IRQ  per-line enable, 1 = enabled
// cpu_i_flag      in   1      CPU status I bit; 1 = IRQ masked
// instr_boundary  in   1      one-cycle pulse: CPU is between instructions
// brk_req         in   1      CPU decoded BRK; valid with instr_boundary
// rti_req         in   1      CPU decoded RTI; valid with instr_boundary
// ih_done         in   1      interrupt_handler finished; one-cycle pulse
// ih_start        out  1      one-cycle start pulse to interrupt_handler
// ih_kind         out  3      0 RESET, 1 NMI, 2 IRQ, 3 BRK, 4 RTI; held from DISPATCH through WAIT_DONE
// ih_is_rti       out  1      ih_kind==4; drives interrupt_handler is_rti
// ih_break_flag   out  1      ih_kind==3; drives interrupt_handler break_flag
// cpu_stall       out  1      high in DISPATCH and WAIT_DONE
// nmi_pending     out  1      NMI latch, visible for debug
// timeout_err     out  1      sticky; set on WAIT_DONE timeout, cleared only by rst
// BEHAVIOUR
// - Reset (rst=0): all outputs 0. Exceptions: reset_pending=1 (power-on vector fetch) and state=IDLE.
//   nmi_q, block_int and the counter all clear.
// - NMI source: nmi_lvl = ppu_status[7] & ppu_nmi_en; nmi_q registers it.
//   Rising edge (nmi_lvl & ~nmi_q) sets nmi_pending. Setting nmi_en while vblank is already high counts as an edge.
//   nmi_pending clears only on the cycle an NMI is dispatched. An edge on that same cycle re-sets it (set wins).
// - IRQ: irq_act = |(irq_lines & irq_mask) & ~cpu_i_flag. Evaluated level-wise at dispatch, not latched.
// - RESET: soft_reset==0 sampled on any clk sets reset_pending. Cleared when RESET is dispatched.
// - States: IDLE, DISPATCH, WAIT_DONE.
// - IDLE -> DISPATCH, evaluated in priority order:
//   1. reset_pending: dispatched immediately, no boundary needed.
//   2. At instr_boundary: NMI if nmi_pending & ~block_int; else BRK if brk_req; else RTI if rti_req;
//      else IRQ if irq_act & ~block_int.
//   3. instr_boundary with nothing selected: stay IDLE and clear block_int.
// - DISPATCH (1 cycle): ih_start=1, ih_kind valid, counter=0. -> WAIT_DONE.
// - WAIT_DONE: counter++ each cycle.
//   - ih_done: -> IDLE. Set block_int=1 if kind was NMI, IRQ or BRK.
//   - counter==DONE_TIMEOUT-1 without done: set timeout_err, -> IDLE.
// - block_int forces at least one instruction between consecutive NMI/IRQ services. RESET ignores block_int.
// - Simultaneous events:
//   - soft_reset during WAIT_DONE only latches. RESET dispatches after the current done/timeout.
//   - brk_req and rti_req both high: BRK wins.
//   - ih_done in IDLE or DISPATCH is ignored.
// - rst asserted mid-operation: immediate return to reset values; any in-flight handshake is abandoned.
// - Latency: boundary pulse -> ih_start = 1 cycle (registered state). cpu_stall rises with ih_start.
// TESTING
// 1. Release rst, soft_reset=1 -> cycle 1: ih_start=1, ih_kind=0; stall until ih_done; then no further start.
// 2. nmi_en=1, ppu_status 00->80 mid-instruction -> nmi_pending=1; next boundary: ih_kind=1, nmi_pending=0.
//    Vblank held at 80 -> no second NMI.
// 3. irq_lines=0001, mask=0001: with I=1 and boundaries -> no start. I=0 -> kind=2.
//    Next boundary after done -> no start (block_int); following boundary -> kind=2 again.
// 4. Boundary with brk_req=1, rti_req=1, IRQ active -> kind=3, ih_break_flag=1.
//    rti_req alone -> kind=4, ih_is_rti=1.
// 5. DONE_TIMEOUT=8, ih_done never -> timeout_err=1 exactly 8 cycles after ih_start; state IDLE, cpu_stall=0.
// 6. soft_reset=0 during WAIT_DONE of NMI -> ih_done; then next cycle kind=0 without a boundary.
//    rst pulse mid-WAIT_DONE -> all outputs 0.

Source files
------------

// File: rtl/interrupt_request_controller_if.sv
// Start/done handshake between the interrupt request controller
// and interrupt_handler.
interface interrupt_request_controller_if;
  logic       ih_start;
  logic [2:0] ih_kind;
  logic       ih_is_rti;
  logic       ih_break_flag;
  logic       ih_done;

  modport master (
    output ih_start,
    output ih_kind,
    output ih_is_rti,
    output ih_break_flag,
    input  ih_done
  );

  modport slave (
    input  ih_start,
    input  ih_kind,
    input  ih_is_rti,
    input  ih_break_flag,
    output ih_done
  );
endinterface

// File: rtl/interrupt_request_controller.sv
// Prioritises RESET/NMI/IRQ/BRK/RTI requests, starts interrupt_handler
// and stalls the CPU core until the handler reports done.
module interrupt_request_controller #(
  parameter int N_IRQ        = 4,
  parameter int DONE_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             soft_reset,
  input  logic [7:0]       ppu_status,
  input  logic             ppu_nmi_en,
  input  logic [N_IRQ-1:0] irq_lines,
  input  logic [N_IRQ-1:0] irq_mask,
  input  logic             cpu_i_flag,
  input  logic             instr_boundary,
  input  logic             brk_req,
  input  logic             rti_req,
  interrupt_request_controller_if.master ih,
  output logic             cpu_stall,
  output logic             nmi_pending,
  output logic             timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DISPATCH,
    S_WAIT
  } state_e;

  typedef enum logic [2:0] {
    K_RESET = 3'd0,
    K_NMI   = 3'd1,
    K_IRQ   = 3'd2,
    K_BRK   = 3'd3,
    K_RTI   = 3'd4
  } kind_e;

  localparam logic [7:0] TMO = 8'(DONE_TIMEOUT - 1);

  state_e     state_q, state_d;
  kind_e      kind_q, kind_d;
  logic [7:0] cnt_q, cnt_d;
  logic       blk_q, blk_d;
  logic       rstp_q, rstp_d;
  logic       nmi_q;
  logic       nmip_q, nmip_d;
  logic       terr_q, terr_d;
  logic       clr_rst, clr_nmi;
  logic       nmi_lvl, irq_act, busy;
  logic       sel_nmi, sel_brk, sel_rti, sel_irq;
  logic [2:0] kind_o;
  logic       unused_status;

  assign unused_status = ^ppu_status[6:0];

  assign nmi_lvl = ppu_status[7] & ppu_nmi_en;
  assign irq_act = |(irq_lines & irq_mask) & ~cpu_i_flag;

  // One-hot boundary selection so the decoder below is exclusive
  assign sel_nmi = nmip_q & ~blk_q;
  assign sel_brk = ~sel_nmi & brk_req;
  assign sel_rti = ~sel_nmi & ~brk_req & rti_req;
  assign sel_irq = ~sel_nmi & ~brk_req & ~rti_req
                 & irq_act & ~blk_q;

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    cnt_d   = cnt_q;
    blk_d   = blk_q;
    terr_d  = terr_q;
    clr_rst = 1'b0;
    clr_nmi = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (rstp_q) begin
          state_d = S_DISPATCH;
          kind_d  = K_RESET;
          clr_rst = 1'b1;
        end else if (instr_boundary) begin
          unique case (1'b1)
            sel_nmi: begin
              state_d = S_DISPATCH;
              kind_d  = K_NMI;
              clr_nmi = 1'b1;
            end
            sel_brk: begin
              state_d = S_DISPATCH;
              kind_d  = K_BRK;
            end
            sel_rti: begin
              state_d = S_DISPATCH;
              kind_d  = K_RTI;
            end
            sel_irq: begin
              state_d = S_DISPATCH;
              kind_d  = K_IRQ;
            end
            default: blk_d = 1'b0;
          endcase
        end
      end
      S_DISPATCH: begin
        cnt_d   = cnt_q + 8'd1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (ih.ih_done) begin
          state_d = S_IDLE;
          if (kind_q inside {K_NMI, K_IRQ, K_BRK})
            blk_d = 1'b1;
        end else if (cnt_q >= TMO) begin
          state_d = S_IDLE;
          terr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    rstp_d = (rstp_q & ~clr_rst) | ~soft_reset;
    nmip_d = (nmip_q & ~clr_nmi) | (nmi_lvl & ~nmi_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      kind_q  <= K_RESET;
      cnt_q   <= '0;
      blk_q   <= 1'b0;
      rstp_q  <= 1'b1;
      nmi_q   <= 1'b0;
      nmip_q  <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
      rstp_q  <= rstp_d;
      nmi_q   <= nmi_lvl;
      nmip_q  <= nmip_d;
      terr_q  <= terr_d;
    end
  end

  assign busy             = (state_q != S_IDLE);
  assign kind_o           = busy ? kind_q : 3'd0;
  assign ih.ih_start      = (state_q == S_DISPATCH);
  assign ih.ih_kind       = kind_o;
  assign ih.ih_is_rti     = (kind_o == 3'd4);
  assign ih.ih_break_flag = (kind_o == 3'd3);
  assign cpu_stall        = busy;
  assign nmi_pending      = nmip_q;
  assign timeout_err      = terr_q;

endmodule

// File: tb/tb_interrupt_request_controller.sv
// Scenario bench for interrupt_request_controller with a
// transaction-level reference model for the randomized run.
module tb_interrupt_request_controller;
  localparam int DT = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       soft_reset;
  logic [7:0] ppu_status;
  logic       ppu_nmi_en;
  logic [3:0] irq_lines;
  logic [3:0] irq_mask;
  logic       cpu_i_flag;
  logic       instr_boundary;
  logic       brk_req;
  logic       rti_req;
  logic       cpu_stall;
  logic       nmi_pending;
  logic       timeout_err;

  int checks = 0;
  int errors = 0;

  interrupt_request_controller_if ihb();

  interrupt_request_controller #(
    .N_IRQ(4),
    .DONE_TIMEOUT(DT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .soft_reset(soft_reset),
    .ppu_status(ppu_status),
    .ppu_nmi_en(ppu_nmi_en),
    .irq_lines(irq_lines),
    .irq_mask(irq_mask),
    .cpu_i_flag(cpu_i_flag),
    .instr_boundary(instr_boundary),
    .brk_req(brk_req),
    .rti_req(rti_req),
    .ih(ihb),
    .cpu_stall(cpu_stall),
    .nmi_pending(nmi_pending),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Reference model: one service in flight, age = cycles since start.
  bit m_busy, m_rp, m_np, m_prev, m_blk, m_terr;
  int m_age, m_kind;

  task automatic model_edge();
    bit lvl, edg, clrn, clrr, irqa;
    if (!rst) begin
      m_busy = 0; m_rp = 1; m_np = 0; m_prev = 0;
      m_blk = 0; m_terr = 0; m_age = 0; m_kind = 0;
      return;
    end
    lvl  = ppu_status[7] && ppu_nmi_en;
    edg  = lvl && !m_prev;
    irqa = (|(irq_lines & irq_mask)) && !cpu_i_flag;
    clrn = 0; clrr = 0;
    if (!m_busy) begin
      if (m_rp) begin
        m_busy = 1; m_age = 0; m_kind = 0; clrr = 1;
      end else if (instr_boundary) begin
        if (m_np && !m_blk) begin
          m_busy = 1; m_age = 0; m_kind = 1; clrn = 1;
        end else if (brk_req) begin
          m_busy = 1; m_age = 0; m_kind = 3;
        end else if (rti_req) begin
          m_busy = 1; m_age = 0; m_kind = 4;
        end else if (irqa && !m_blk) begin
          m_busy = 1; m_age = 0; m_kind = 2;
        end else begin
          m_blk = 0;
        end
      end
    end else if (m_age == 0) begin
      m_age = 1;
    end else if (ihb.ih_done) begin
      m_busy = 0;
      if (m_kind >= 1 && m_kind <= 3) m_blk = 1;
    end else if (m_age >= DT - 1) begin
      m_busy = 0; m_terr = 1;
    end else begin
      m_age++;
    end
    m_rp   = (m_rp && !clrr) || !soft_reset;
    m_np   = (m_np && !clrn) || edg;
    m_prev = lvl;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    instr_boundary = 0;
    brk_req = 0;
    rti_req = 0;
    ihb.ih_done = 0;
  endtask

  task automatic finish_service();
    step();
    ihb.ih_done = 1;
    step();
  endtask

  task automatic test_reset();
    rst = 0; soft_reset = 1; ppu_status = 0; ppu_nmi_en = 0;
    irq_lines = 0; irq_mask = 0; cpu_i_flag = 1;
    instr_boundary = 0; brk_req = 0; rti_req = 0; ihb.ih_done = 0;
    repeat (3) step();
    checks++; if (ihb.ih_start !== 1'b0) begin errors++; $display("FAIL rst_start got=%0b exp=0", ihb.ih_start); end
    checks++; if (ihb.ih_kind !== 3'd0) begin errors++; $display("FAIL rst_kind got=%0d exp=0", ihb.ih_kind); end
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL rst_stall got=%0b exp=0", cpu_stall); end
    checks++; if (nmi_pending !== 1'b0 || timeout_err !== 1'b0) begin errors++; $display("FAIL rst_flags got=%0b%0b exp=00", nmi_pending, timeout_err); end
    rst = 1;
    step();
    checks++; if (ihb.ih_start !== 1'b1 || ihb.ih_kind !== 3'd0) begin errors++; $display("FAIL por_start got=%0b/%0d exp=1/0", ihb.ih_start, ihb.ih_kind); end
    checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL por_stall got=%0b exp=1", cpu_stall); end
    repeat (2) step();
    checks++; if (ihb.ih_start !== 1'b0 || cpu_stall !== 1'b1) begin errors++; $display("FAIL por_wait got=%0b/%0b exp=0/1", ihb.ih_start, cpu_stall); end
    ihb.ih_done = 1;
    step();
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL por_done got=%0b exp=0", cpu_stall); end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (ihb.ih_start !== 1'b0) begin errors++; $display("FAIL por_again c%0d got=%0b exp=0", i, ihb.ih_start); end
    end
  endtask

  task automatic test_nmi();
    ppu_nmi_en = 1; ppu_status = 8'h00;
    step();
    ppu_status = 8'h80;
    step();
    checks++; if (nmi_pending !== 1'b1 || ihb.ih_start !== 1'b0) begin errors++; $display("FAIL nmi_latch got=%0b/%0b exp=1/0", nmi_pending, ihb.ih_start); end
    repeat ($urandom_range(1, 4)) step();
    instr_boundary = 1;
    step();
    checks++; if (ihb.ih_start !== 1'b1 || ihb.ih_kind !== 3'd1) begin errors++; $display("FAIL nmi_start got=%0b/%0d exp=1/1", ihb.ih_start, ihb.ih_kind); end
    checks++; if (nmi_pending !== 1'b0) begin errors++; $display("FAIL nmi_clear got=%0b exp=0", nmi_pending); end
    finish_service();
    for (int i = 0; i < 3; i++) begin
      instr_boundary = 1;
      step();
      checks++; if (ihb.ih_start !== 1'b0 || nmi_pending !== 1'b0) begin errors++; $display("FAIL nmi_held b%0d got=%0b/%0b exp=0/0", i, ihb.ih_start, nmi_pending); end
    end
    ppu_status = 8'h00;
    step();
  endtask

  task automatic test_irq();
    int ln;
    ln = $urandom_range(0, 3);
    irq_lines = 4'b0001 << ln;
    irq_mask = ~(4'b0001 << ln);
    cpu_i_flag = 0;
    instr_boundary = 1;
    step();
    checks++; if (ihb.ih_start !== 1'b0) begin errors++; $display("FAIL irq_masked_line got=%0b exp=0", ihb.ih_start); end
    irq_mask = 4'b0001 << ln;
    cpu_i_flag = 1;
    for (int i = 0; i < 2; i++) begin
      instr_boundary = 1;
      step();
      checks++; if (ihb.ih_start !== 1'b0) begin errors++; $display("FAIL irq_iflag b%0d got=%0b exp=0", i, ihb.ih_start); end
    end
    cpu_i_flag = 0;
    instr_boundary = 1;
    step();
    checks++; if (ihb.ih_start !== 1'b1 || ihb.ih_kind !== 3'd2) begin errors++; $display("FAIL irq_start got=%0b/%0d exp=1/2", ihb.ih_start, ihb.ih_kind); end
    finish_service();
    instr_boundary = 1;
    step();
    checks++; if (ihb.ih_start !== 1'b0) begin errors++; $display("FAIL irq_block got=%0b exp=0", ihb.ih_start); end
    instr_boundary = 1;
    step();
    checks++; if (ihb.ih_start !== 1'b1 || ihb.ih_kind !== 3'd2) begin errors++; $display("FAIL irq_again got=%0b/%0d exp=1/2", ihb.ih_start, ihb.ih_kind); end
    finish_service();
    irq_lines = 0;
    instr_boundary = 1;
    step();
  endtask

  task automatic test_brk_rti();
    irq_lines = 4'b1111; irq_mask = 4'b1111; cpu_i_flag = 0;
    instr_boundary = 1; brk_req = 1; rti_req = 1;
    step();
    checks++; if (ihb.ih_kind !== 3'd3 || ihb.ih_break_flag !== 1'b1 || ihb.ih_is_rti !== 1'b0) begin errors++; $display("FAIL brk_win got=%0d/%0b/%0b exp=3/1/0", ihb.ih_kind, ihb.ih_break_flag, ihb.ih_is_rti); end
    finish_service();
    irq_lines = 0;
    instr_boundary = 1; rti_req = 1;
    step();
    checks++; if (ihb.ih_start !== 1'b1 || ihb.ih_kind !== 3'd4 || ihb.ih_is_rti !== 1'b1) begin errors++; $display("FAIL rti got=%0b/%0d/%0b exp=1/4/1", ihb.ih_start, ihb.ih_kind, ihb.ih_is_rti); end
    checks++; if (ihb.ih_break_flag !== 1'b0) begin errors++; $display("FAIL rti_brkflag got=%0b exp=0", ihb.ih_break_flag); end
    finish_service();
    instr_boundary = 1;
    step();
  endtask

  task automatic test_timeout();
    int n;
    instr_boundary = 1; brk_req = 1;
    step();
    checks++; if (ihb.ih_start !== 1'b1 || timeout_err !== 1'b0) begin errors++; $display("FAIL tmo_start got=%0b/%0b exp=1/0", ihb.ih_start, timeout_err); end
    n = 0;
    while (timeout_err !== 1'b1 && n < 3 * DT) begin
      step();
      n++;
    end
    checks++; if (n != DT) begin errors++; $display("FAIL tmo_cycles got=%0d exp=%0d", n, DT); end
    checks++; if (cpu_stall !== 1'b0 || ihb.ih_start !== 1'b0) begin errors++; $display("FAIL tmo_idle got=%0b/%0b exp=0/0", cpu_stall, ihb.ih_start); end
    repeat (3) step();
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_sticky got=%0b exp=1", timeout_err); end
    instr_boundary = 1;
    step();
  endtask

  task automatic test_soft_reset();
    ppu_nmi_en = 1; ppu_status = 8'h00;
    step();
    ppu_status = 8'h80;
    step();
    instr_boundary = 1;
    step();
    checks++; if (ihb.ih_kind !== 3'd1) begin errors++; $display("FAIL sr_nmi got=%0d exp=1", ihb.ih_kind); end
    step();
    soft_reset = 0;
    step();
    soft_reset = 1;
    repeat (2) step();
    checks++; if (cpu_stall !== 1'b1 || ihb.ih_kind !== 3'd1) begin errors++; $display("FAIL sr_latch got=%0b/%0d exp=1/1", cpu_stall, ihb.ih_kind); end
    ihb.ih_done = 1;
    step();
    step();
    checks++; if (ihb.ih_start !== 1'b1 || ihb.ih_kind !== 3'd0) begin errors++; $display("FAIL sr_dispatch got=%0b/%0d exp=1/0", ihb.ih_start, ihb.ih_kind); end
    step();
    ppu_status = 8'h00;
    rst = 0;
    #1;
    checks++; if (ihb.ih_start !== 1'b0 || cpu_stall !== 1'b0 || ihb.ih_kind !== 3'd0) begin errors++; $display("FAIL rst_mid got=%0b/%0b/%0d exp=0/0/0", ihb.ih_start, cpu_stall, ihb.ih_kind); end
    checks++; if (nmi_pending !== 1'b0 || timeout_err !== 1'b0) begin errors++; $display("FAIL rst_mid_flags got=%0b/%0b exp=0/0", nmi_pending, timeout_err); end
    step();
    rst = 1;
    step();
    finish_service();
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      soft_reset = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 7) == 0) ppu_status = 8'($urandom);
      if ($urandom_range(0, 19) == 0) ppu_nmi_en = ~ppu_nmi_en;
      if ($urandom_range(0, 3) == 0) begin
        irq_lines = 4'($urandom);
        irq_mask = 4'($urandom);
        cpu_i_flag = 1'($urandom);
      end
      instr_boundary = !m_busy && ($urandom_range(0, 2) == 0);
      brk_req = instr_boundary && ($urandom_range(0, 5) == 0);
      rti_req = instr_boundary && ($urandom_range(0, 5) == 0);
      ihb.ih_done = ($urandom_range(0, 7) == 0);
      step();
      checks++; if (ihb.ih_start !== (m_busy && m_age == 0)) begin errors++; $display("FAIL rnd_start c%0d got=%0b exp=%0b", c, ihb.ih_start, m_busy && m_age == 0); end
      checks++; if (ihb.ih_kind !== 3'(m_busy ? m_kind : 0)) begin errors++; $display("FAIL rnd_kind c%0d got=%0d exp=%0d", c, ihb.ih_kind, m_busy ? m_kind : 0); end
      checks++; if (ihb.ih_is_rti !== (m_busy && m_kind == 4) || ihb.ih_break_flag !== (m_busy && m_kind == 3)) begin errors++; $display("FAIL rnd_flags c%0d got=%0b%0b exp=%0b%0b", c, ihb.ih_is_rti, ihb.ih_break_flag, m_busy && m_kind == 4, m_busy && m_kind == 3); end
      checks++; if (cpu_stall !== m_busy) begin errors++; $display("FAIL rnd_stall c%0d got=%0b exp=%0b", c, cpu_stall, m_busy); end
      checks++; if (nmi_pending !== m_np) begin errors++; $display("FAIL rnd_nmi c%0d got=%0b exp=%0b", c, nmi_pending, m_np); end
      checks++; if (timeout_err !== m_terr) begin errors++; $display("FAIL rnd_tmo c%0d got=%0b exp=%0b", c, timeout_err, m_terr); end
    end
  endtask

  initial begin
    test_reset();
    test_nmi();
    test_irq();
    test_brk_rti();
    test_timeout();
    test_soft_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
